// File: rtl/event_fifo.sv
// event_fifo: synchronous first-word-fall-through FIFO for packed (x,y) event
// coordinates. The head word is presented combinationally from the register
// array. Occupancy, overflow/underflow stickies and a saturating drop counter
// are kept alongside so downstream stages can detect lost events.
module event_fifo #(
    parameter int COORD_BITS         = 8,
    parameter int DEPTH              = 16,
    parameter int ALMOST_FULL_THRESH = DEPTH - 2,
    parameter int DROP_CNT_BITS      = 16
) (
    input  logic                          clk,
    input  logic                          reset_i,
    input  logic                          write_i,
    input  logic [2*COORD_BITS-1:0]       write_data_i,
    output logic                          full_o,
    output logic                          almost_full_o,
    input  logic                          fifo_read_i,
    output logic                          fifo_empty_o,
    output logic [2*COORD_BITS-1:0]       fifo_data_o,
    output logic [$clog2(DEPTH):0]        fill_count_o,
    output logic                          overflow_o,
    output logic                          underflow_o,
    output logic [DROP_CNT_BITS-1:0]      drop_count_o,
    input  logic                          clear_status_i
);

    localparam int DW = 2 * COORD_BITS;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0]            mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CW-1:0]            fill_count;
    logic                     overflow;
    logic                     underflow;
    logic [DROP_CNT_BITS-1:0] drop_count;

    logic full;
    logic empty;
    logic rd_acc;
    logic wr_acc;
    logic drop;
    logic under_evt;

    // Handshake decode. A read frees a slot in the same cycle, so a write
    // into a full FIFO still lands when a read accompanies it.
    always_comb begin
        full      = (fill_count == CW'(DEPTH));
        empty     = (fill_count == '0);
        rd_acc    = fifo_read_i & ~empty;
        wr_acc    = write_i & (~full | rd_acc);
        drop      = write_i & ~wr_acc;
        under_evt = fifo_read_i & empty;
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset_i)
            mem[wr_ptr] <= write_data_i;
    end

    // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr_acc && !rd_acc)
                fill_count <= fill_count + CW'(1);
            else if (rd_acc && !wr_acc)
                fill_count <= fill_count - CW'(1);
        end
    end

    // Sticky status and saturating drop counter; a same-cycle event beats clear.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            drop_count <= '0;
        end else if (clear_status_i) begin
            overflow   <= drop;
            underflow  <= under_evt;
            drop_count <= drop ? DROP_CNT_BITS'(1) : '0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            if (under_evt)
                underflow <= 1'b1;
            if (drop && drop_count != {DROP_CNT_BITS{1'b1}})
                drop_count <= drop_count + DROP_CNT_BITS'(1);
        end
    end

    // Outputs depend on registered state only.
    always_comb begin
        full_o        = full;
        fifo_empty_o  = empty;
        almost_full_o = (fill_count >= CW'(ALMOST_FULL_THRESH));
        fill_count_o  = fill_count;
        fifo_data_o   = mem[rd_ptr];
        overflow_o    = overflow;
        underflow_o   = underflow;
        drop_count_o  = drop_count;
    end

endmodule

// File: tb/tb_event_fifo.sv
// Testbench for event_fifo (DEPTH=16, 8-bit coordinates): a vector table,
// hand-written corner sequences, and randomized traffic against a queue model.
module tb_event_fifo;

    logic        clk = 1'b0;
    logic        reset_i, write_i, fifo_read_i, clear_status_i;
    logic [15:0] write_data_i;
    logic        full_o, almost_full_o, fifo_empty_o, overflow_o, underflow_o;
    logic [15:0] fifo_data_o;
    logic [4:0]  fill_count_o;
    logic [15:0] drop_count_o;

    event_fifo #(.COORD_BITS(8), .DEPTH(16), .ALMOST_FULL_THRESH(14), .DROP_CNT_BITS(16)) dut (
        .clk(clk), .reset_i(reset_i), .write_i(write_i), .write_data_i(write_data_i),
        .full_o(full_o), .almost_full_o(almost_full_o), .fifo_read_i(fifo_read_i),
        .fifo_empty_o(fifo_empty_o), .fifo_data_o(fifo_data_o), .fill_count_o(fill_count_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o), .drop_count_o(drop_count_o),
        .clear_status_i(clear_status_i)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    logic [15:0] q[$];
    bit          m_ovf, m_udf;
    int          m_drop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the spec rules, sample #1 after the edge.
    task automatic cyc(input logic w, input logic [15:0] d, input logic r,
                       input logic c, input logic rs);
        bit mempty, mfull, racc, wacc;
        write_i = w; write_data_i = d; fifo_read_i = r;
        clear_status_i = c; reset_i = rs;
        mempty = (q.size() == 0);
        mfull  = (q.size() == 16);
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete(); m_ovf = 0; m_udf = 0; m_drop = 0;
        end else begin
            racc = r && !mempty;
            wacc = w && (!mfull || racc);
            if (c) begin m_ovf = 0; m_udf = 0; m_drop = 0; end
            if (racc) void'(q.pop_front());
            if (wacc) q.push_back(d);
            if (w && !wacc) begin
                m_ovf = 1;
                if (m_drop != 65535) m_drop++;
            end
            if (r && mempty) m_udf = 1;
        end
    endtask

    task automatic check_model(input int t);
        string s;
        s = $sformatf("rnd%0d", t);
        chk({s, "_empty"}, 32'(fifo_empty_o), 32'(q.size() == 0));
        chk({s, "_full"},  32'(full_o),       32'(q.size() == 16));
        chk({s, "_afull"}, 32'(almost_full_o), 32'(q.size() >= 14));
        chk({s, "_cnt"},   32'(fill_count_o), 32'(q.size()));
        chk({s, "_ovf"},   32'(overflow_o),   32'(m_ovf));
        chk({s, "_udf"},   32'(underflow_o),  32'(m_udf));
        chk({s, "_drop"},  32'(drop_count_o), 32'(m_drop));
        if (q.size() != 0)
            chk({s, "_head"}, 32'(fifo_data_o), 32'(q[0]));
    endtask

    typedef struct {
        logic rs, w, r, c;
        logic [15:0] d;
        logic e_empty, e_full;
        int e_cnt;
        logic [15:0] e_data;
        logic e_ovf, e_udf;
        int e_drop;
    } vec_t;

    vec_t vt[14];

    initial begin
        int next_w, got, t;
        logic w, r;
        write_i = 0; write_data_i = 0; fifo_read_i = 0; clear_status_i = 0; reset_i = 1;

        //          rs w r c  d         empty full cnt data     ovf udf drop
        vt[0]  = '{1, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 0, 16'h0A0F, 0, 0, 1, 16'h0A0F, 0, 0, 0};
        vt[2]  = '{0, 0, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0};
        vt[3]  = '{0, 0, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0};
        vt[4]  = '{0, 0, 0, 1, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0};
        vt[5]  = '{0, 1, 1, 0, 16'h1111, 0, 0, 1, 16'h1111, 0, 1, 0};
        vt[6]  = '{0, 0, 1, 1, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0};
        vt[7]  = '{0, 0, 1, 1, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0};
        vt[8]  = '{0, 1, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 0};
        vt[9]  = '{0, 1, 0, 0, 16'h1F1F, 0, 0, 2, 16'h0000, 0, 1, 0};
        vt[10] = '{0, 1, 1, 0, 16'h0F1F, 0, 0, 2, 16'h1F1F, 0, 1, 0};
        vt[11] = '{0, 0, 1, 0, 16'h0000, 0, 0, 1, 16'h0F1F, 0, 1, 0};
        vt[12] = '{0, 0, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0};
        vt[13] = '{0, 0, 0, 1, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0};

        for (int i = 0; i < 14; i++) begin
            string s;
            s = $sformatf("vec%0d", i);
            cyc(vt[i].w, vt[i].d, vt[i].r, vt[i].c, vt[i].rs);
            chk({s, "_empty"}, 32'(fifo_empty_o), 32'(vt[i].e_empty));
            chk({s, "_full"},  32'(full_o),       32'(vt[i].e_full));
            chk({s, "_afull"}, 32'(almost_full_o), 32'(0));
            chk({s, "_cnt"},   32'(fill_count_o), 32'(vt[i].e_cnt));
            chk({s, "_ovf"},   32'(overflow_o),   32'(vt[i].e_ovf));
            chk({s, "_udf"},   32'(underflow_o),  32'(vt[i].e_udf));
            chk({s, "_drop"},  32'(drop_count_o), 32'(vt[i].e_drop));
            if (!vt[i].e_empty)
                chk({s, "_data"}, 32'(fifo_data_o), 32'(vt[i].e_data));
        end

        // Fill to full, check almost_full threshold and full flag.
        for (int i = 0; i < 16; i++) begin
            cyc(1, 16'(i), 0, 0, 0);
            chk($sformatf("fill%0d_cnt", i), 32'(fill_count_o), 32'(i + 1));
            chk($sformatf("fill%0d_afull", i), 32'(almost_full_o), 32'(i + 1 >= 14));
            chk($sformatf("fill%0d_full", i), 32'(full_o), 32'(i + 1 == 16));
        end
        // Dropped write while full.
        cyc(1, 16'hFFFF, 0, 0, 0);
        chk("drop_ovf", 32'(overflow_o), 32'(1));
        chk("drop_cnt", 32'(drop_count_o), 32'(1));
        chk("drop_fill", 32'(fill_count_o), 32'(16));
        chk("drop_head", 32'(fifo_data_o), 32'(0));
        // Simultaneous read and write while full.
        cyc(1, 16'h1234, 1, 0, 0);
        chk("fullrw_fill", 32'(fill_count_o), 32'(16));
        chk("fullrw_drop", 32'(drop_count_o), 32'(1));
        chk("fullrw_head", 32'(fifo_data_o), 32'(1));
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d", k), 32'(fifo_data_o), (k < 15) ? 32'(k + 1) : 32'h1234);
            cyc(0, 0, 1, 0, 0);
        end
        chk("drain_empty", 32'(fifo_empty_o), 32'(1));
        chk("drain_udf", 32'(underflow_o), 32'(0));
        cyc(0, 0, 0, 1, 0);
        chk("clr_ovf", 32'(overflow_o), 32'(0));
        chk("clr_drop", 32'(drop_count_o), 32'(0));

        // Reset with 5 entries stored (reset beats a concurrent write/read).
        for (int i = 0; i < 5; i++) cyc(1, 16'(16'h0100 + i), 0, 0, 0);
        chk("pre_rst_cnt", 32'(fill_count_o), 32'(5));
        cyc(1, 16'hAAAA, 1, 1, 1);
        chk("rst_empty", 32'(fifo_empty_o), 32'(1));
        chk("rst_cnt", 32'(fill_count_o), 32'(0));
        chk("rst_full", 32'(full_o), 32'(0));

        // Order and wrap: 40 words, source respects full_o, reader at half rate.
        next_w = 0; got = 0; t = 0;
        while (got < 40 && t < 400) begin
            w = (next_w < 40) && !full_o;
            r = (t % 2 == 1) && !fifo_empty_o;
            if (r) begin
                chk($sformatf("order%0d", got), 32'(fifo_data_o), 32'(got));
                got++;
            end
            cyc(w, 16'(next_w), r, 0, 0);
            if (w) next_w++;
            t++;
        end
        chk("order_count", 32'(got), 32'(40));
        chk("order_ovf", 32'(overflow_o), 32'(0));

        // Randomized traffic against the queue model.
        for (int i = 0; i < 800; i++) begin
            int pw, pr;
            pw = (i < 400) ? 70 : 35;
            pr = (i < 400) ? 35 : 70;
            cyc($urandom_range(0, 99) < pw, 16'($urandom), $urandom_range(0, 99) < pr,
                $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
            check_model(i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/event_fifo.md
# event_fifo

Synchronous first-word-fall-through event FIFO that buffers packed (x,y) event coordinates from upstream event producers. It sits directly in front of `event_capture` and drives that block's `fifo_empty_i` / `fifo_data_i` and consumes its `fifo_read_o`. It also reports fill level, overflow and underflow, and keeps a count of dropped events so the convolution/pooling pipeline can detect back-pressure loss.

## Interface
- `COORD_BITS`, default 8: bits per coordinate; data word is 2*COORD_BITS.
- `DEPTH`, default 16: entries; power of two, ≥ 2.
- `ALMOST_FULL_THRESH`, default DEPTH-2: `almost_full_o` asserts when fill_count ≥ this value; legal range 1..DEPTH.
- `DROP_CNT_BITS`, default 16: width of the saturating drop counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `write_i`  in  1  push request.
- `write_data_i`  in  2*COORD_BITS  packed coord per `conv_pool_pkg::pack_coordinates`, stored opaquely.
- `full_o`  out  1  fill_count == DEPTH.
- `almost_full_o`  out  1  fill_count ≥ ALMOST_FULL_THRESH.
- `fifo_read_i`  in  1  pop request from `event_capture`.
- `fifo_empty_o`  out  1  fill_count == 0.
- `fifo_data_o`  out  2*COORD_BITS  head entry; valid whenever `fifo_empty_o` = 0.
- `fill_count_o`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow_o`  out  1  sticky: a write was dropped.
- `underflow_o`  out  1  sticky: a read was issued while empty.
- `drop_count_o`  out  DROP_CNT_BITS  saturating count of dropped writes.
- `clear_status_i`  in  1  clears `overflow_o`, `underflow_o`, `drop_count_o`.

## Operation
- Storage: DEPTH-entry register array. `wr_ptr` and `rd_ptr` are each $clog2(DEPTH) bits and wrap naturally modulo DEPTH. `fill_count` is a separate register, DEPTH+1 states.
- FWFT: `fifo_data_o` = mem[rd_ptr], read combinationally from the registered array. No read latency.
- Write accepted = `write_i` & (!full | read accepted). When accepted: mem[wr_ptr] ← `write_data_i`, then wr_ptr+1.
- Read accepted = `fifo_read_i` & !empty. When accepted: rd_ptr+1.
- fill_count update: +1 on write only, −1 on read only, unchanged on both or neither.
- Full with simultaneous read and write: both are accepted. Count stays DEPTH. The new word goes into the slot just vacated.
- Empty with simultaneous read and write: the write is accepted and the read is ignored. `underflow_o` sets. Count becomes 1.
- Write rejected (full, no read): data is discarded. `overflow_o` ← 1. `drop_count_o` increments and saturates at all-ones.
- Read while empty: no pointer change. `underflow_o` ← 1.
- `clear_status_i`: clears the sticky flags and the counter. If a drop or underflow occurs in the same cycle, the new event wins and the flag reads 1 (counter reads 1).
- Memory contents are not reset. `fifo_data_o` is don't-care while empty.

## Timing
- Reset (`reset_i` = 1 at an edge): pointers and fill_count go to 0. After that edge the outputs are `fifo_empty_o`=1, `full_o`=0, `almost_full_o`=0 (0 if ALMOST_FULL_THRESH ≥ 1), `fill_count_o`=0, `overflow_o`=0, `underflow_o`=0, `drop_count_o`=0.
- Reset overrides write, read and clear in the same cycle. Reset mid-burst discards all contents.
- Write-to-visible latency is 1 cycle. A write at edge N gives `fifo_empty_o`=0 and `fifo_data_o` = that word in the cycle after edge N.
- Pop: `fifo_read_i` high at edge N advances the head. The next word (or `fifo_empty_o`=1) is visible after edge N. `event_capture` samples `fifo_data_o` in the same cycle it asserts `fifo_read_o`.
- All status outputs are registered or derived from registered state only. No combinational path from `write_i` or `fifo_read_i` to any output.
- Sustained throughput is 1 write + 1 read per cycle.

## Test plan
- Reset then single write of pack(10,15), no read. Required response:
  - Next cycle: `fifo_empty_o`=0, `fifo_data_o`=0x0A0F, `fill_count_o`=1.
  - After a read edge: `fifo_empty_o`=1, `fill_count_o`=0.
- Order and wrap-around: write 40 sequential words 0..39 while reading at half rate (DEPTH=16). Required response: the read-back sequence is exactly 0..39 with no gaps, and no overflow is flagged.
- Full boundary: 16 writes, then write 0xFFFF with no read. Required response:
  - `full_o`=1, `almost_full_o`=1 from fill count 14.
  - `overflow_o`=1, `drop_count_o`=1.
  - Head still holds the 1st word.
- Full with simultaneous read and write of 0x1234. Required response: `fill_count_o` stays 16, no drop, and 0x1234 is read out last.
- Empty corner cases. Required response:
  - `fifo_read_i`=1 when empty: `underflow_o`=1, pointers unchanged.
  - Simultaneous read and write when empty: `fill_count_o`=1, and the written word appears at the head.
- `clear_status_i` pulse: sticky flags and counter return to 0. Then reset with 5 entries stored: after the reset edge, `fifo_empty_o`=1 and `fill_count_o`=0. Back-to-back `event_capture` integration reproduces coordinates (0,0), (31,31) and (15,31) in order.
